// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a synchronous FIFO, bursts bounded to MAX_BURST beats.
// Define FIFO_ARB_PRIO0_EN to give requester 0 strict priority when a new owner is chosen.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   owner_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_nxt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   beat_cnt_nxt;
  logic [CNT_W-1:0]   beat_inc;
  logic [NUM_REQ-1:0] gnt_nxt;

  logic [PTR_W-1:0]   pick;
  logic               pick_valid;
  logic [PTR_W:0]     cand;
  logic               owner_req;
  logic [DATA_WIDTH-1:0] owner_data;
  logic               accept;
  logic               last_beat;

  // Search starts at rr_ptr and wraps, so the most recent owner is visited last.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!pick_valid && req[cand[PTR_W-1:0]]) begin
        pick       = cand[PTR_W-1:0];
        pick_valid = 1'b1;
      end
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0]) begin
      pick       = '0;
      pick_valid = 1'b1;
    end
`else
`endif
  end

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == PTR_W'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept    = (state == OWN) && owner_req && !fifo_full;
  assign beat_inc  = beat_cnt + 1'b1;
  assign last_beat = (beat_inc == CNT_W'(MAX_BURST));

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    beat_cnt_nxt  = beat_cnt;
    gnt_nxt       = gnt;
    ack           = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt    = OWN;
          owner_nxt    = pick;
          beat_cnt_nxt = '0;
          gnt_nxt      = NUM_REQ'(1) << pick;
        end
      end
      OWN: begin
        busy = 1'b1;
        if (accept) begin
          ack           = NUM_REQ'(1) << owner;
          fifo_write_en = 1'b1;
          fifo_data_in  = owner_data;
          beat_cnt_nxt  = beat_inc;
        end
        // A full FIFO stalls the burst but a dropped request still ends it.
        if (!owner_req || (accept && last_beat)) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          rr_ptr_nxt = (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      gnt      <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 requesters, 8-bit data, bursts of 4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int writes = 0;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .gnt           (gnt),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [3:0] r, input logic f, input logic [31:0] d);
    @(negedge clk);
    req       = r;
    fifo_full = f;
    req_data  = d;
    #1;
    if (fifo_write_en === 1'b1) writes++;
  endtask

  task automatic runVector(input string tag, input logic [3:0] r, input logic f, input logic [31:0] d,
                           input logic e_we, input logic [7:0] e_data, input logic [3:0] e_gnt);
    applyStimulus(r, f, d);
    checkOutput({tag, ".gnt"},  32'(gnt),           32'(e_gnt));
    checkOutput({tag, ".ack"},  32'(ack),           e_we ? 32'(e_gnt) : 32'd0);
    checkOutput({tag, ".we"},   32'(fifo_write_en), 32'(e_we));
    checkOutput({tag, ".data"}, 32'(fifo_data_in),  32'(e_data));
    checkOutput({tag, ".busy"}, 32'(busy),          32'(e_gnt != 4'b0));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".gnt"},  32'(gnt),           32'd0);
    checkOutput({tag, ".ack"},  32'(ack),           32'd0);
    checkOutput({tag, ".we"},   32'(fifo_write_en), 32'd0);
    checkOutput({tag, ".data"}, 32'(fifo_data_in),  32'd0);
    checkOutput({tag, ".busy"}, 32'(busy),          32'd0);
  endtask

  initial begin
    int          ph;
    int          o;
    logic [31:0] d;
    logic [3:0]  eg;
    logic [7:0]  ed;

    reset     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = '0;

    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'($urandom), 1'($urandom), $urandom);
      checkQuiet("rst");
    end
    req       = '0;
    fifo_full = 1'b0;
    reset     = 1'b1;

    // Rotation: five-cycle period, one idle bubble then four beats per owner.
    for (int k = 0; k < 25; k++) begin
      ph = k % 5;
      o  = (k / 5) % 4;
      d  = '0;
      eg = '0;
      ed = '0;
      if (ph != 0) begin
        d[o*8 +: 8] = 8'(o*16 + ph - 1);
        eg          = 4'(1 << o);
        ed          = 8'(o*16 + ph - 1);
      end
      runVector("rot", 4'b1111, 1'b0, d, ph != 0, ed, eg);
    end

    runVector("sb0", 4'b0100, 1'b0, 32'h0021_0000, 1'b0, 8'h00, 4'b0000);
    runVector("sb1", 4'b0100, 1'b0, 32'h0021_0000, 1'b1, 8'h21, 4'b0100);
    runVector("sb2", 4'b0100, 1'b0, 32'h0022_0000, 1'b1, 8'h22, 4'b0100);
    runVector("sb3", 4'b0100, 1'b0, 32'h0023_0000, 1'b1, 8'h23, 4'b0100);
    runVector("sb4", 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 4'b0100);
    runVector("sb5", 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 4'b0000);

    writes = 0;
    runVector("bp0", 4'b0010, 1'b0, 32'h0000_B000, 1'b0, 8'h00, 4'b0000);
    runVector("bp1", 4'b0010, 1'b0, 32'h0000_B000, 1'b1, 8'hB0, 4'b0010);
    runVector("bp2", 4'b0010, 1'b0, 32'h0000_B100, 1'b1, 8'hB1, 4'b0010);
    runVector("bp3", 4'b0010, 1'b1, 32'h0000_B200, 1'b0, 8'h00, 4'b0010);
    runVector("bp4", 4'b0010, 1'b1, 32'h0000_B200, 1'b0, 8'h00, 4'b0010);
    runVector("bp5", 4'b0010, 1'b1, 32'h0000_B200, 1'b0, 8'h00, 4'b0010);
    runVector("bp6", 4'b0010, 1'b0, 32'h0000_B200, 1'b1, 8'hB2, 4'b0010);
    runVector("bp7", 4'b0010, 1'b0, 32'h0000_B300, 1'b1, 8'hB3, 4'b0010);
    runVector("bp8", 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 4'b0000);
    checkOutput("bp.count", 32'(writes), 32'd4);

    runVector("rm0", 4'b1000, 1'b0, 32'hC000_0000, 1'b0, 8'h00, 4'b0000);
    runVector("rm1", 4'b1000, 1'b0, 32'hC000_0000, 1'b1, 8'hC0, 4'b1000);
    runVector("rm2", 4'b1000, 1'b0, 32'hC100_0000, 1'b1, 8'hC1, 4'b1000);
    reset = 1'b0;
    #1;
    checkQuiet("rm.mid");
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    runVector("rp0", 4'b1000, 1'b0, 32'hC000_0000, 1'b0, 8'h00, 4'b0000);
    runVector("rp1", 4'b1000, 1'b0, 32'hC000_0000, 1'b1, 8'hC0, 4'b1000);
    runVector("rp2", 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 4'b1000);

    // Requesters 0 and 1 compete; with priority enabled requester 0 wins every grant.
    for (int k = 0; k < 15; k++) begin
      ph = k % 5;
`ifdef FIFO_ARB_PRIO0_EN
      o = 0;
`else
      o = (k / 5) % 2;
`endif
      eg = '0;
      ed = '0;
      if (ph != 0) begin
        eg = 4'(1 << o);
        ed = (o == 0) ? 8'h50 : 8'h60;
      end
      runVector("prio", 4'b0011, 1'b0, 32'h0000_6050, ph != 0, ed, eg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the synchronous FIFO between NUM_REQ producers.
- Round-robin arbitration with bounded bursts: an owner keeps the port for up to MAX_BURST accepted beats, then ownership rotates.
- Sits directly in front of the FIFO. fifo_write_en/fifo_data_in drive FIFO write_en/data_in; FIFO full feeds fifo_full.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, FIFO data width
MAX_BURST, 4, max beats per grant (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester write request; held with data until ack
req_data  input  NUM_REQ*DATA_WIDTH  flat data bus, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  output  NUM_REQ  beat accepted this cycle (one-hot or zero)
gnt  output  NUM_REQ  current owner (one-hot or zero), registered
fifo_full  input  1  FIFO full flag
fifo_write_en  output  1  FIFO write strobe
fifo_data_in  output  DATA_WIDTH  FIFO write data
busy  output  1  high in OWN state

Behaviour:
- Reset (reset=0, async): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, gnt=0, busy=0. Combinational outputs follow: ack=0, fifo_write_en=0, fifo_data_in=0.
- FSM: two states, IDLE and OWN.
- IDLE:
  - If any req, pick the first asserted index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch it as owner, clear beat_cnt, go to OWN.
  - No ack or write in IDLE. First beat is therefore 1 cycle after req rises.
- OWN:
  - gnt = one-hot(owner), busy=1.
  - Beat accepted when req[owner] && !fifo_full. That cycle: ack[owner]=1, fifo_write_en=1, fifo_data_in = owner's slice, beat_cnt++.
  - ack, fifo_write_en and fifo_data_in are combinational from state/req/fifo_full. When not writing, fifo_data_in=0.
- Release from OWN to IDLE, with rr_ptr = (owner+1) mod NUM_REQ, when either:
  - req[owner]=0, or
  - an accepted beat makes beat_cnt reach MAX_BURST.
- After release there is one IDLE bubble cycle before the next grant.
- fifo_full=1 in OWN:
  - No ack or write; beat_cnt holds; ownership holds.
  - Release still occurs if req[owner] drops.
- Requests from non-owners are ignored until the next IDLE; they never get ack.
- Width rules:
  - beat_cnt width = clog2(MAX_BURST+1).
  - rr_ptr/owner width = clog2(NUM_REQ), minimum 1.
  - rr_ptr wraps NUM_REQ-1 -> 0.
- The arbiter never writes while fifo_full=1, so no FIFO overflow can originate here.
- Reset mid-burst: outputs clear immediately; the interrupted burst is abandoned (no replay).

Optional Feature:
- Macro: FIFO_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. In IDLE, req[0]=1 always selects owner 0 regardless of rr_ptr; other requesters use round-robin among themselves only when req[0]=0.
- Undefined: pure round-robin as above.
- All other rules (bursts, stall, release) are identical in both builds.

Test Plan:
- Reset: hold reset=0 with random req/fifo_full -> gnt=0, ack=0, fifo_write_en=0, busy=0. Release reset; first grant goes to lowest requesting index from rr_ptr=0.
- Single burst: req[2]=1 for 3 beats, data 0x21, 0x22, 0x23 advanced on each ack, then req[2]=0 -> gnt=4'b0100 from cycle+1. Three consecutive fifo_write_en with data 0x21/0x22/0x23, then return to IDLE.
- Rotation: req=4'b1111 held, data = requester*0x10 + beat -> owners 0,1,2,3,0 in order. Each burst is exactly 4 writes; one idle cycle between bursts. FIFO receives 0x00-0x03, 0x10-0x13, ...
- Backpressure: req[1] burst, fifo_full=1 for 3 cycles after 2nd beat -> no write/ack during stall, gnt stays 4'b0010. Beats 3-4 complete after full drops; total of exactly 4 writes.
- Reset mid-burst: assert reset during beat 2 of owner 3 -> same-cycle gnt=0, fifo_write_en=0. After release, rr_ptr=0 and req[3]-only is re-granted from IDLE.
- FIFO_ARB_PRIO0_EN: req=4'b0011 held -> owner 0 every grant, requester 1 never acked. Without the macro, owners alternate 0,1,0,1.
